// File: rtl/mem_pkg.sv
// Shared definitions for the memory line responder: FSM encoding and line geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W      = 4;

endpackage

// File: rtl/line_ram.sv
// Line storage: 2^IDX_W x LINE_W array, synchronous write, registered read with
// write-first bypass and a forced-zero read for out-of-range requests.
module line_ram
  import mem_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] mem [0:(1<<IDX_W)-1];

  // NOTE: the array has no reset; clearing it would force a flop-based memory
  // and its contents are defined only by the loader anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The output register holds its value until the next read; a same-edge
  // write to the read index is forwarded so the caller sees the new line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data <= '0;
      end else if (we && (wr_idx == rd_idx)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// CPU-facing line responder: detects address changes, waits LATENCY edges,
// then presents the addressed line (or zero plus ram_err when out of range).
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int IDX_W   = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_data,
  output logic              ram_ready,
  output logic              ram_err,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [LINE_W-1:0] ld_data
);

  state_e state, state_d;

  // Only the line part of the address is kept: offset changes are not requests.
  logic [ADDR_W-1:OFFSET_W] last_addr;
  logic [CNT_W-1:0]         cnt;
  logic                     pending;
  logic                     ready_q;
  logic                     err_q;

  logic                     addr_changed;
  logic                     line_hit;
  logic                     start;
  logic                     finish;
  logic [IDX_W-1:0]         last_idx;
  logic                     last_oor;
  logic                     unused_offset;

  assign unused_offset = ^ram_addr[OFFSET_W-1:0];

  assign addr_changed = (ram_addr[ADDR_W-1:OFFSET_W] != last_addr);
  assign last_idx     = last_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign last_oor     = |last_addr[ADDR_W-1:IDX_W+OFFSET_W];
  // A loader write to the line on display makes it stale.
  assign line_hit     = ld_en && (ld_idx == last_idx) && !err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pending || addr_changed) begin
          start   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An address change restarts the fetch; the old one never completes.
        if (pending || addr_changed) begin
          start = 1'b1;
        end else if (cnt == '0) begin
          finish  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (pending || addr_changed || line_hit) begin
          start   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_addr <= '0;
      cnt       <= '0;
      pending   <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending <= 1'b0;
      if (start) begin
        last_addr <= ram_addr[ADDR_W-1:OFFSET_W];
        cnt       <= CNT_W'(LATENCY - 1);
        ready_q   <= 1'b0;
        err_q     <= 1'b0;
      end else if (finish) begin
        ready_q <= 1'b1;
        err_q   <= last_oor;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  line_ram #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_line_ram (
    .clk     (clk),
    .rstn    (rstn),
    .we      (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_en   (finish),
    .rd_zero (last_oor),
    .rd_idx  (last_idx),
    .rd_data (ram_data)
  );

  assign ram_ready = ready_q;
  assign ram_err   = err_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: fetch latency, restart, range error,
// write-first, stale refetch, sub-line offsets and asynchronous reset.
module tb_mem_line_responder;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int IDX_W  = 8;

  logic              clk;
  logic              rstn;
  logic [ADDR_W-1:0] ram_addr;
  logic [LINE_W-1:0] ram_data;
  logic              ram_ready;
  logic              ram_err;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [LINE_W-1:0] ld_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_66 = {16{8'h66}};
  localparam logic [LINE_W-1:0] LINE_77 = {16{8'h77}};
  localparam logic [LINE_W-1:0] LINE_C3 = {16{8'hC3}};
  localparam logic [LINE_W-1:0] LINE_19 = {16{8'h19}};

  mem_line_responder #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .IDX_W   (IDX_W),
    .LATENCY (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_ready (ram_ready),
    .ram_err   (ram_err),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IDX_W-1:0] idx, input logic [LINE_W-1:0] data);
    ld_en   = 1'b1;
    ld_idx  = idx;
    ld_data = data;
    step();
    ld_en   = 1'b0;
  endtask

  // Request edge followed by LATENCY-1 quiet edges; ready must stay low.
  task automatic expect_wait(input string tag, input int edges);
    for (int i = 0; i < edges; i++) begin
      step();
      check(tag, LINE_W'(ram_ready), LINE_W'(1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rstn     = 1'b0;
    ram_addr = '0;
    ld_en    = 1'b0;
    ld_idx   = '0;
    ld_data  = '0;
    #2;
    check("rst_ready", LINE_W'(ram_ready), LINE_W'(1'b0));
    check("rst_err",   LINE_W'(ram_err),   LINE_W'(1'b0));
    check("rst_data",  ram_data,           '0);

    // Loader writes are honoured while reset is held.
    load(8'd5, LINE_A5);
    load(8'd6, LINE_66);

    // Basic fetch: ready exactly 3 edges after the first post-reset edge.
    ram_addr = 32'h50;
    rstn     = 1'b1;
    expect_wait("basic_wait", 3);
    step();
    check("basic_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("basic_data",  ram_data,           LINE_A5);
    check("basic_err",   LINE_W'(ram_err),   LINE_W'(1'b0));

    // Out of range.
    ram_addr = 32'h0000_1000;
    expect_wait("oor_wait", 3);
    check("oor_err_wait", LINE_W'(ram_err), LINE_W'(1'b0));
    step();
    check("oor_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("oor_err",   LINE_W'(ram_err),   LINE_W'(1'b1));
    check("oor_data",  ram_data,           '0);

    // Address change one edge into WAIT: 0x50 never answers.
    ram_addr = 32'h50;
    step();
    ram_addr = 32'h60;
    expect_wait("restart_wait", 3);
    step();
    check("restart_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("restart_data",  ram_data,           LINE_66);

    // Settle on 0x50, then move within the line.
    ram_addr = 32'h50;
    expect_wait("settle_wait", 3);
    step();
    check("settle_data", ram_data, LINE_A5);
    ram_addr = 32'h5C;
    step();
    step();
    check("offset_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("offset_data",  ram_data,           LINE_A5);

    // Write to another line leaves the response alone.
    load(8'd9, LINE_19);
    check("miss_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("miss_data",  ram_data,           LINE_A5);

    // Write hit in RESP: ready drops on the write edge, returns 3 edges later.
    load(8'd5, LINE_77);
    check("hit_drop", LINE_W'(ram_ready), LINE_W'(1'b0));
    check("hit_hold", ram_data,           LINE_A5);
    step();
    step();
    check("hit_wait", LINE_W'(ram_ready), LINE_W'(1'b0));
    step();
    check("hit_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("hit_data",  ram_data,           LINE_77);

    // Write on the completing edge is forwarded.
    ram_addr = 32'h60;
    expect_wait("wf_wait", 3);
    load(8'd6, LINE_C3);
    check("wf_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("wf_data",  ram_data,           LINE_C3);

    // Reset in the middle of WAIT: outputs clear immediately, refetch follows.
    ram_addr = 32'h50;
    step();
    step();
    rstn = 1'b0;
    #1;
    check("arst_ready", LINE_W'(ram_ready), LINE_W'(1'b0));
    check("arst_data",  ram_data,           '0);
    check("arst_err",   LINE_W'(ram_err),   LINE_W'(1'b0));
    step();
    rstn = 1'b1;
    expect_wait("arst_wait", 3);
    step();
    check("arst_refetch_ready", LINE_W'(ram_ready), LINE_W'(1'b1));
    check("arst_refetch_data",  ram_data,           LINE_77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the byte address from the CPU.
REQ-002 SHALL have parameter LINE_W, default 128, meaning the width of a memory line in bits (16 bytes).
REQ-003 SHALL have parameter IDX_W, default 8, meaning log2 of the line count (256 lines).
REQ-004 SHALL have parameter LATENCY, default 3, meaning the number of read-latency cycles; the legal range is 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ram_addr, input, ADDR_W bits: the byte address driven by the CPU.
REQ-008 SHALL have port ram_data, output, LINE_W bits: the line returned to the CPU.
REQ-009 SHALL have port ram_ready, output, 1 bit: ram_data is valid for the current ram_addr.
REQ-010 SHALL have port ram_err, output, 1 bit: the current ram_addr is outside the implemented range.
REQ-011 SHALL have port ld_en, input, 1 bit: backdoor line-write strobe used by the bench/loader.
REQ-012 SHALL have port ld_idx, input, IDX_W bits: the line index for the backdoor write.
REQ-013 SHALL have port ld_data, input, LINE_W bits: the line data for the backdoor write.

Function
REQ-014 SHALL compute the line index as ram_addr[IDX_W+3:4]; ram_addr[3:0] are ignored.
REQ-015 SHALL treat an address as out of range when any bit of ram_addr[ADDR_W-1:IDX_W+4] is nonzero.
REQ-016 SHALL register the last accepted address in last_addr and detect a new request at any rising edge where ram_addr != last_addr, or where a pending flag is set.
REQ-017 SHALL implement the FSM states IDLE, WAIT and RESP.
- IDLE to WAIT on a new request.
- WAIT to RESP when the counter reaches 0.
- RESP to WAIT on a new request.
REQ-018 SHALL, on the new-request edge, capture last_addr, load cnt with LATENCY-1, clear ram_ready and ram_err, and hold ram_data at its old value.
REQ-019 SHALL, in WAIT, decrement cnt on each edge; on the edge where cnt==0, load ram_data, set ram_ready=1 and ram_err per REQ-015, and enter RESP.
- ram_ready is therefore first high LATENCY edges after the request edge.
REQ-020 SHALL drive ram_data to all-zero when the address is out of range; otherwise ram_data is the array line at the index.
REQ-021 SHALL restart the fetch on an address change during WAIT (REQ-018 applies); the old fetch is discarded with no ram_ready pulse.
REQ-022 SHALL commit a backdoor write (ld_en=1) to the array on the rising edge, in every state.
REQ-023 SHALL make a backdoor write to the line being read on the same edge as the final WAIT read visible in ram_data (write-first).
REQ-024 SHALL mark a ram_data held in RESP stale on a backdoor write to the displayed index, triggering a refetch: ram_ready drops and returns after LATENCY edges.
REQ-025 SHALL keep ram_data, ram_ready and ram_err constant in RESP while ram_addr is stable and no write hits the line.

Reset
REQ-026 SHALL, while rstn=0, immediately force ram_data=0, ram_ready=0, ram_err=0, state=IDLE, cnt=0, last_addr=0 and pending=1.
REQ-027 SHALL leave array contents unaffected by reset; the array is uninitialised until loaded.
REQ-028 SHALL, on the first edge after rstn rises, issue a fetch of the current ram_addr via pending, then clear pending.
REQ-029 SHALL abandon any in-flight fetch when reset is asserted mid-WAIT; no ram_ready follows.

Structure
REQ-030 SHALL place the FSM state encoding (2-bit) and the constants LINE_BYTES=16 and OFFSET_W=4 in the shared package mem_pkg.
REQ-031 SHALL implement the storage as one sub-module, line_ram: a synchronous single-read/single-write array of 2^IDX_W x LINE_W with write-first bypass.

Verification
REQ-032 SHALL cover a basic fetch: load idx 5 = 0x...A5; hold rstn low, then release; ram_addr=0x50 -> ram_ready=1 with ram_data=0x...A5 exactly 3 edges after the request edge.
REQ-033 SHALL cover address change mid-WAIT: ram_addr 0x50 then 0x60 after 1 edge -> no ready for 0x50; ram_ready 3 edges after the change, data=line 6.
REQ-034 SHALL cover out of range: ram_addr=0x00001000 -> ram_ready=1, ram_err=1, ram_data=0 after 3 edges.
REQ-035 SHALL cover a write hit in RESP: ram_addr=0x50 settled; ld idx 5 = 0x...77 -> ram_ready low next edge, high 3 edges later with 0x...77.
REQ-036 SHALL cover reset mid-WAIT: rstn=0 for 1 cycle during WAIT -> outputs 0 asynchronously; refetch completes 3 edges after release.
REQ-037 SHALL cover sub-line offset: ram_addr 0x50 then 0x5C -> no new request; ram_ready stays 1.
